multi_stepper_engine: RTL

MULTI_STEPPER_ENGINE -- requirements
Module: multi_stepper_engine

---
 rtl/multi_stepper_pkg.sv | 28 ++
 rtl/multi_stepper_engine_if.sv | 35 +++
 rtl/stepper_channel.sv | 126 ++++++++++++
 rtl/multi_stepper_engine.sv | 67 ++++++
 4 files changed

// File: rtl/multi_stepper_pkg.sv
// ============================================================================
// Package  : multi_stepper_pkg
// Brief    : shared types and coil phase table for the multi-channel stepper
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_stepper_pkg;

    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_MOVE = 1'b1
    } ch_state_e;

    typedef enum logic [0:0] {
        STEP_FULL = 1'b0,
        STEP_HALF = 1'b1
    } step_mode_e;

    // Half-step sequence; even indices are single-coil, odd are two-coil.
    localparam logic [3:0] c_phase_table [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

endpackage

`default_nettype wire

// File: rtl/multi_stepper_engine_if.sv
// ============================================================================
// Interface : multi_stepper_engine_if
// Brief     : command channel into the multi-channel stepper engine
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multi_stepper_engine_if #(
    parameter int NUM_CH = 2,
    parameter int POS_W  = 8,
    parameter int DLY_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic             cmd_stop;
    logic [POS_W-1:0] cmd_target;
    logic [DLY_W-1:0] cmd_delay;
    logic             cmd_half_step;

    modport master (
        output cmd_valid, cmd_ch, cmd_stop, cmd_target, cmd_delay, cmd_half_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_stop, cmd_target, cmd_delay, cmd_half_step,
        output cmd_ready
    );

endinterface

`default_nettype wire

// File: rtl/stepper_channel.sv
// ============================================================================
// Module   : stepper_channel
// Brief    : one stepper channel: step timer, position, coil phase and drive
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stepper_channel
    import multi_stepper_pkg::*;
#(
    parameter int POS_W = 8,
    parameter int DLY_W = 8
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             i_load,
    input  wire logic             i_stop,
    input  wire logic [POS_W-1:0] i_target,
    input  wire logic [DLY_W-1:0] i_delay,
    input  wire logic             i_half,
    output logic      [3:0]       o_coils,
    output logic      [POS_W-1:0] o_position,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [POS_W-1:0] c_pos_one = POS_W'(1);
    localparam logic [DLY_W-1:0] c_cnt_one = DLY_W'(1);

    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] r_target;
    logic [DLY_W-1:0] r_delay;
    logic [DLY_W-1:0] r_cnt;
    logic [2:0]       r_phase;
    step_mode_e       r_mode;
    logic             r_done;
    logic [3:0]       r_coils;

    logic             w_same;
    logic             w_up;
    logic             w_start;
    logic             w_take_step;
    logic             w_arrive;
    logic [2:0]       w_phase_step;
    logic [2:0]       w_phase_nxt;
    logic [POS_W-1:0] w_pos_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_take_step  = 1'b0;
        w_arrive     = 1'b0;
        w_same       = (i_target == r_pos);
        w_start      = 1'b0;
        w_up         = (r_target > r_pos);
        w_phase_step = (r_mode == STEP_HALF) ? 3'd1 : 3'd2;
        w_pos_nxt    = w_up ? (r_pos + c_pos_one) : (r_pos - c_pos_one);
        w_phase_nxt  = w_up ? (r_phase + w_phase_step) : (r_phase - w_phase_step);
        case (r_state)
            CH_IDLE: begin
                if (i_load && !w_same) begin
                    w_start     = 1'b1;
                    w_state_nxt = CH_MOVE;
                end
            end
            CH_MOVE: begin
                // A stop on the same edge as a due step suppresses the step.
                if (i_stop) begin
                    w_state_nxt = CH_IDLE;
                end else if (r_cnt == '0) begin
                    w_take_step = 1'b1;
                    if (w_pos_nxt == r_target) begin
                        w_arrive    = 1'b1;
                        w_state_nxt = CH_IDLE;
                    end
                end
            end
            default: w_state_nxt = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= CH_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pos    <= '0;
            r_target <= '0;
            r_delay  <= '0;
            r_cnt    <= '0;
            r_phase  <= 3'd0;
            r_mode   <= STEP_FULL;
            r_done   <= 1'b0;
            r_coils  <= c_phase_table[0];
        end else begin
            r_coils <= c_phase_table[r_phase];
            r_done  <= w_arrive || ((r_state == CH_IDLE) && i_load && w_same);
            if (w_start) begin
                r_target <= i_target;
                r_delay  <= i_delay;
                r_cnt    <= i_delay;
                r_mode   <= i_half ? STEP_HALF : STEP_FULL;
            end else if (w_take_step) begin
                r_pos   <= w_pos_nxt;
                r_phase <= w_phase_nxt;
                r_cnt   <= r_delay;
            end else if ((r_state == CH_MOVE) && !i_stop) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
        end
    end

    assign o_coils    = r_coils;
    assign o_position = r_pos;
    assign o_busy     = (r_state == CH_MOVE);
    assign o_done     = r_done;

endmodule

`default_nettype wire

// File: rtl/multi_stepper_engine.sv
// ============================================================================
// Module   : multi_stepper_engine
// Brief    : command decode and ready logic over NUM_CH stepper channels
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_stepper_engine
    import multi_stepper_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int POS_W  = 8,
    parameter int DLY_W  = 8
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    multi_stepper_engine_if.slave         cmd,
    output logic      [4*NUM_CH-1:0]      stepper_signals,
    output logic      [POS_W*NUM_CH-1:0]  position,
    output logic      [NUM_CH-1:0]        busy,
    output logic      [NUM_CH-1:0]        done
);

    localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_pad_n = 1 << c_ch_w;

    logic [c_pad_n-1:0] w_busy_pad;
    logic               w_ch_ok;
    logic               w_accept;

    // Pad busy so out-of-range channel indices read as idle instead of X.
    always_comb begin
        w_busy_pad             = '0;
        w_busy_pad[NUM_CH-1:0] = busy;
    end

    assign w_ch_ok       = (32'(cmd.cmd_ch) < NUM_CH);
    assign cmd.cmd_ready = cmd.cmd_stop || !w_ch_ok || !w_busy_pad[cmd.cmd_ch];
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready && w_ch_ok;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic w_sel;
            assign w_sel = w_accept && (cmd.cmd_ch == c_ch_w'(g));

            stepper_channel #(
                .POS_W (POS_W),
                .DLY_W (DLY_W)
            ) u_channel (
                .clk        (clk),
                .reset_n    (reset_n),
                .i_load     (w_sel && !cmd.cmd_stop),
                .i_stop     (w_sel && cmd.cmd_stop),
                .i_target   (cmd.cmd_target),
                .i_delay    (cmd.cmd_delay),
                .i_half     (cmd.cmd_half_step),
                .o_coils    (stepper_signals[4*g +: 4]),
                .o_position (position[POS_W*g +: POS_W]),
                .o_busy     (busy[g]),
                .o_done     (done[g])
            );
        end
    endgenerate

endmodule

`default_nettype wire
